// File: rtl/spec_uart_feeder_pkg.sv
// Shared constants and helpers for the UART feeder in front of the tsp solver.
// The ASCII values are the same ones tsp uses when it parses the problem file.
package spec_uart_feeder_pkg;

    typedef logic [7:0] byte_t;

    localparam byte_t ASCII_CR = 8'd13;
    localparam byte_t ASCII_LF = 8'd10;
    localparam byte_t ASCII_0  = 8'd48;
    localparam byte_t ASCII_9  = 8'd57;

    function automatic logic is_digit(input byte_t b);
        return (b >= ASCII_0) && (b <= ASCII_9);
    endfunction

endpackage

// File: rtl/spec_uart_feeder_if.sv
// Byte handshake between the feeder and tsp.
//   ready_to_read : tsp -> feeder, tsp accepts a byte this cycle
//   specdata      : feeder -> tsp, byte at the FIFO head
//   has_specdata  : feeder -> tsp, byte valid and consumed this cycle
interface spec_uart_feeder_if;
    import spec_uart_feeder_pkg::*;

    logic  ready_to_read;
    byte_t specdata;
    logic  has_specdata;

    modport master (output specdata, output has_specdata, input ready_to_read);
    modport slave  (input specdata, input has_specdata, output ready_to_read);

endinterface

// File: rtl/spec_uart_feeder_uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchroniser, falling-edge start detect,
// mid-bit sampling with a down-counter bit timer.
// Ports:
//   clk, rst          : clock, async active-low reset
//   rxd               : raw serial line, idle high
//   rx_valid, rx_byte : one-cycle pulse with the received byte (good stop bit)
//   frame_err_pulse   : one-cycle pulse when the stop bit is sampled low
//
// state    | meaning
// ---------+-----------------------------------------------------
// ST_IDLE  | line idle, waiting for a falling edge on rxd_s
// ST_START | half-bit wait, then confirm the start bit is still low
// ST_DATA  | sample 8 data bits, LSB first, one per bit period
// ST_STOP  | sample the stop bit, emit byte or frame error
module uart_rx_core
    import spec_uart_feeder_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  rxd,
    output logic  rx_valid,
    output byte_t rx_byte,
    output logic  frame_err_pulse
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic          rxd_meta;
    logic          rxd_s;
    logic          rxd_prev;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    byte_t         shift_q;
    logic          edge_pend;
    logic          falling;
    logic          expired;

    assign falling = rxd_prev & ~rxd_s;
    assign expired = (cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_meta        <= 1'b1;
            rxd_s           <= 1'b1;
            rxd_prev        <= 1'b1;
            state           <= ST_IDLE;
            cnt             <= '0;
            bit_idx         <= '0;
            shift_q         <= '0;
            edge_pend       <= 1'b0;
            rx_valid        <= 1'b0;
            rx_byte         <= '0;
            frame_err_pulse <= 1'b0;
        end else begin
            rxd_meta        <= rxd;
            rxd_s           <= rxd_meta;
            rxd_prev        <= rxd_s;
            rx_valid        <= 1'b0;
            frame_err_pulse <= 1'b0;
            edge_pend       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // edge_pend covers a start edge that landed on the stop-sample cycle
                    if (falling || edge_pend) begin
                        cnt   <= HALF_LOAD;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (expired) begin
                        if (!rxd_s) begin
                            cnt     <= BIT_LOAD;
                            bit_idx <= '0;
                            state   <= ST_DATA;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (expired) begin
                        shift_q <= {rxd_s, shift_q[7:1]};
                        cnt     <= BIT_LOAD;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    if (expired) begin
                        if (rxd_s) begin
                            rx_valid <= 1'b1;
                            rx_byte  <= shift_q;
                        end else begin
                            frame_err_pulse <= 1'b1;
                        end
                        edge_pend <= falling;
                        state     <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/spec_uart_feeder.sv
// UART front end for tsp: receives the problem file, folds CR/LF/CRLF
// into a single CR, and buffers bytes in a FIFO drained by tsp.
// Ports:
//   clk, rst   : clock, async active-low reset
//   uart_rxd   : raw serial line from the board pin
//   tsp_bus    : specdata / has_specdata / ready_to_read handshake
//   fifo_count : FIFO occupancy
//   frame_err  : sticky, a stop bit was sampled low
//   overflow   : sticky, a byte was dropped because the FIFO was full
module spec_uart_feeder
    import spec_uart_feeder_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 868,
    parameter int FIFO_ADDR_BITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    uart_rxd,
    spec_uart_feeder_if.master      tsp_bus,
    output logic [FIFO_ADDR_BITS:0] fifo_count,
    output logic                    frame_err,
    output logic                    overflow
);

    localparam int DEPTH = 1 << FIFO_ADDR_BITS;
    localparam logic [FIFO_ADDR_BITS:0] DEPTH_CNT = {1'b1, {FIFO_ADDR_BITS{1'b0}}};

    logic  rx_valid;
    byte_t rx_byte;
    logic  frame_err_pulse;

    uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk             (clk),
        .rst             (rst),
        .rxd             (uart_rxd),
        .rx_valid        (rx_valid),
        .rx_byte         (rx_byte),
        .frame_err_pulse (frame_err_pulse)
    );

    // line-ending normaliser
    logic  prev_was_cr;
    logic  prev_cr_n;
    logic  push_en;
    byte_t push_byte;

    always_comb begin
        push_en   = 1'b0;
        push_byte = rx_byte;
        prev_cr_n = prev_was_cr;
        if (rx_valid) begin
            if (rx_byte == ASCII_CR) begin
                push_en   = 1'b1;
                prev_cr_n = 1'b1;
            end else if (rx_byte == ASCII_LF) begin
                if (prev_was_cr) begin
                    prev_cr_n = 1'b0;
                end else begin
                    push_en   = 1'b1;
                    push_byte = ASCII_CR;
                end
            end else begin
                push_en   = 1'b1;
                prev_cr_n = 1'b0;
            end
        end
    end

    // FIFO
    byte_t                   mem [DEPTH];
    logic [FIFO_ADDR_BITS-1:0] wr_ptr;
    logic [FIFO_ADDR_BITS-1:0] rd_ptr;
    logic [FIFO_ADDR_BITS-1:0] rd_ptr_n;
    logic [FIFO_ADDR_BITS:0]   count;
    byte_t                   head_q;
    logic                    pop;
    logic                    push_ok;

    assign tsp_bus.has_specdata = tsp_bus.ready_to_read && (count != '0);
    assign tsp_bus.specdata     = head_q;
    assign pop                  = tsp_bus.has_specdata;
    // a pop in the same cycle frees the slot a full FIFO would otherwise refuse
    assign push_ok              = push_en && ((count != DEPTH_CNT) || pop);
    assign rd_ptr_n             = pop ? rd_ptr + 1'b1 : rd_ptr;
    assign fifo_count           = count;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_byte;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            head_q      <= '0;
            prev_was_cr <= 1'b0;
            frame_err   <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            prev_was_cr <= prev_cr_n;
            if (frame_err_pulse) begin
                frame_err <= 1'b1;
            end
            if (push_en && !push_ok) begin
                overflow <= 1'b1;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_ptr_n;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // head register tracks mem[rd_ptr]; the byte being written wins when it lands there
            if (push_ok || pop) begin
                if (push_ok && (wr_ptr == rd_ptr_n)) begin
                    head_q <= push_byte;
                end else begin
                    head_q <= mem[rd_ptr_n];
                end
            end
        end
    end

endmodule

// File: tb/tb_spec_uart_feeder.sv
module tb_spec_uart_feeder;

    localparam int C = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       uart_rxd = 1'b1;
    logic [4:0] fifo_count;
    logic       frame_err;
    logic       overflow;

    spec_uart_feeder_if bus();

    spec_uart_feeder #(.CLKS_PER_BIT(C), .FIFO_ADDR_BITS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_rxd   (uart_rxd),
        .tsp_bus    (bus),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] got [$];
    logic [7:0] exp_q [$];
    bit         prev_cr_m = 1'b0;
    int         held = 0;
    bit         ovf_exp = 1'b0;

    always @(negedge clk) begin
        if (rst && bus.has_specdata) got.push_back(bus.specdata);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, expv);
        end
    endtask

    // reference model: what tsp should see, given the bytes put on the wire
    task automatic model_emit(input logic [7:0] b);
        if (!bus.ready_to_read && held == 16) begin
            ovf_exp = 1'b1;
        end else begin
            exp_q.push_back(b);
            if (!bus.ready_to_read) held++;
        end
    endtask

    task automatic model_rx(input logic [7:0] b);
        if (b == 8'd13) begin
            model_emit(8'd13);
            prev_cr_m = 1'b1;
        end else if (b == 8'd10) begin
            if (prev_cr_m) prev_cr_m = 1'b0;
            else model_emit(8'd13);
        end else begin
            model_emit(b);
            prev_cr_m = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        uart_rxd = 1'b0;
        repeat (C) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (C) @(posedge clk);
        end
        uart_rxd = stop_ok;
        repeat (C) @(posedge clk);
        uart_rxd = 1'b1;
        repeat (2 * C) @(posedge clk);
        if (stop_ok) model_rx(b);
    endtask

    task automatic compare_stream(input string tag);
        int n;
        check($sformatf("%s_len", tag), got.size(), exp_q.size());
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_byte%0d", tag, i), {24'd0, got[i]}, {24'd0, exp_q[i]});
        got.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_specdata"}, {24'd0, bus.specdata}, 32'd0);
        check({tag, "_has"}, {31'd0, bus.has_specdata}, 32'd0);
        check({tag, "_count"}, {27'd0, fifo_count}, 32'd0);
        check({tag, "_ferr"}, {31'd0, frame_err}, 32'd0);
        check({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
    endtask

    initial begin
        logic [7:0] s1 [5];
        logic [7:0] b;
        s1[0] = 8'h45; s1[1] = 8'h4F; s1[2] = 8'h46; s1[3] = 8'h0D; s1[4] = 8'h0A;
        bus.ready_to_read = 1'b1;

        repeat (3) @(posedge clk);
        #1 check_reset_outputs("rst");
        rst = 1'b1;
        repeat (4) @(posedge clk);

        // single byte
        send_byte(8'h4E, 1'b1);
        #1 check("single_count", {27'd0, fifo_count}, 32'd0);
        compare_stream("single");

        // CRLF folding and bare LF
        for (int i = 0; i < 5; i++) send_byte(s1[i], 1'b1);
        compare_stream("eof");
        send_byte(8'h31, 1'b1);
        send_byte(8'h0A, 1'b1);
        compare_stream("one_lf");

        // one-cycle glitch on idle line
        @(posedge clk);
        uart_rxd = 1'b0;
        @(posedge clk);
        uart_rxd = 1'b1;
        repeat (5 * C) @(posedge clk);
        #1;
        check("glitch_got", got.size(), 0);
        check("glitch_ferr", {31'd0, frame_err}, 32'd0);
        check("glitch_count", {27'd0, fifo_count}, 32'd0);

        // randomized traffic, heavy on CR and LF
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0: b = 8'd10;
                1: b = 8'd13;
                default: b = 8'($urandom_range(0, 255));
            endcase
            send_byte(b, 1'b1);
            repeat ($urandom_range(0, 5)) @(posedge clk);
        end
        compare_stream("random");
        check("random_ovf", {31'd0, overflow}, 32'd0);

        // framing error
        send_byte(8'h55, 1'b0);
        #1;
        check("ferr_set", {31'd0, frame_err}, 32'd1);
        check("ferr_nopush", got.size(), 0);
        send_byte(8'h41, 1'b1);
        compare_stream("after_ferr");

        // overflow with tsp stalled
        bus.ready_to_read = 1'b0;
        held = 0;
        for (int i = 0; i < 18; i++) send_byte(8'(i), 1'b1);
        #1;
        check("ovf_count", {27'd0, fifo_count}, held);
        check("ovf_flag", {31'd0, overflow}, {31'd0, ovf_exp});
        check("ovf_has_low", {31'd0, bus.has_specdata}, 32'd0);
        bus.ready_to_read = 1'b1;
        held = 0;
        repeat (30) @(posedge clk);
        #1 check("ovf_drained", {27'd0, fifo_count}, 32'd0);
        compare_stream("ovf_drain");

        // reset mid-frame with bytes queued
        bus.ready_to_read = 1'b0;
        for (int i = 0; i < 3; i++) send_byte(8'h61 + 8'(i), 1'b1);
        #1 check("pre_rst_count", {27'd0, fifo_count}, held);
        uart_rxd = 1'b0;
        repeat (C) @(posedge clk);
        uart_rxd = 1'b1;
        repeat (2 * C) @(posedge clk);
        rst = 1'b0;
        #1 check_reset_outputs("midrst");
        exp_q.delete();
        got.delete();
        held = 0;
        ovf_exp = 1'b0;
        prev_cr_m = 1'b0;
        repeat (5) @(posedge clk);
        rst = 1'b1;
        bus.ready_to_read = 1'b1;
        repeat (4 * C) @(posedge clk);
        send_byte(8'h32, 1'b1);
        compare_stream("post_rst");
        check("post_rst_ferr", {31'd0, frame_err}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
